// File: rtl/io_port_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bank_pkg
// Description : Register offsets, port stride and address helpers for io_port_bank.
// Revision    : 1.0
// ============================================================================
package io_port_bank_pkg;

  localparam int unsigned PORT_STRIDE = 4;

  // Low two address bits select the register within a port window
  typedef enum logic [1:0] {
    OFF_OUT  = 2'd0,
    OFF_DIR  = 2'd1,
    OFF_IN   = 2'd2,
    OFF_FLAG = 2'd3
  } reg_off_e;

  localparam logic RST_VAL = 1'b0;

  function automatic int unsigned irq_en_addr(input int unsigned num_ports);
    return num_ports * PORT_STRIDE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync.sv
`default_nettype none
// ============================================================================
// Module      : io_sync
// Description : Multi-stage, DATA_W-wide input synchroniser with async reset.
// Revision    : 1.0
// ============================================================================
module io_sync #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bank
// Description : Parametrised GPIO bank: output latch, direction, synchronised
//               input, W1C change flags and a maskable registered interrupt.
// Revision    : 1.0
// ============================================================================
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   pin_in,
  output logic [NUM_PORTS*DATA_W-1:0]   pin_out,
  output logic [NUM_PORTS*DATA_W-1:0]   pin_oe,
  output logic                          irq
);

  localparam int unsigned     C_WARM_W   = $clog2(SYNC_STAGES + 2);
  localparam int unsigned     C_IDX_W    = ADDR_W - 2;
  localparam logic [C_WARM_W-1:0] C_WARM_INIT = C_WARM_W'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0]   C_IRQ_ADDR  = ADDR_W'(irq_en_addr(NUM_PORTS));

  logic [NUM_PORTS-1:0][DATA_W-1:0] out_q, out_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] dir_q, dir_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] flag_q, flag_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] prev_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_in;
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_set, w_clr;
  logic [NUM_PORTS-1:0]             irq_en_q, irq_en_d;
  logic [NUM_PORTS-1:0]             w_sel;
  logic [C_WARM_W-1:0]              warm_q, warm_d;
  logic [DATA_W-1:0]                rd_data_q, w_rd_mux;
  logic                             rd_valid_q;
  logic                             irq_q, irq_d;
  logic                             w_in_range;
  logic                             w_warm_done;
  logic [C_IDX_W-1:0]               w_port_idx;
  reg_off_e                         w_off;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sync
      io_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pin_in[p*DATA_W +: DATA_W]),
        .q_o (w_in[p])
      );
    end
  endgenerate

  assign w_in_range  = (addr < C_IRQ_ADDR);
  assign w_port_idx  = addr[ADDR_W-1:2];
  assign w_off       = reg_off_e'(addr[1:0]);
  assign w_warm_done = (warm_q == '0);

  always_comb begin
    w_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sel[p] = w_in_range && (w_port_idx == C_IDX_W'(p));
    end
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    flag_d   = flag_q;
    irq_en_d = irq_en_q;
    w_set    = '0;
    w_clr    = '0;
    irq_d    = 1'b0;
    warm_d   = warm_q;
    if (!w_warm_done) begin
      warm_d = warm_q - 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr_en && w_sel[p] && (w_off == OFF_OUT)) begin
        out_d[p] = wr_data;
      end
      if (wr_en && w_sel[p] && (w_off == OFF_DIR)) begin
        dir_d[p] = wr_data;
      end
      if (wr_en && w_sel[p] && (w_off == OFF_FLAG)) begin
        w_clr[p] = wr_data;
      end
      // Only input-direction bits may flag, and only once synchronisers have settled
      w_set[p]  = (w_in[p] ^ prev_q[p]) & ~dir_q[p] & {DATA_W{w_warm_done}};
      flag_d[p] = (flag_q[p] & ~w_clr[p]) | w_set[p];
      irq_d     = irq_d | (irq_en_q[p] & (|(flag_q[p] & ~dir_q[p])));
    end
    if (wr_en && (addr == C_IRQ_ADDR)) begin
      irq_en_d = wr_data[NUM_PORTS-1:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (addr == C_IRQ_ADDR) begin
      w_rd_mux = DATA_W'(irq_en_q);
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_sel[p]) begin
        case (w_off)
          OFF_OUT:  w_rd_mux = out_q[p];
          OFF_DIR:  w_rd_mux = dir_q[p];
          OFF_IN:   w_rd_mux = w_in[p];
          OFF_FLAG: w_rd_mux = flag_q[p];
          default:  w_rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      flag_q     <= '0;
      prev_q     <= '0;
      irq_en_q   <= '0;
      warm_q     <= C_WARM_INIT;
      rd_data_q  <= '0;
      rd_valid_q <= RST_VAL;
      irq_q      <= RST_VAL;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      flag_q     <= flag_d;
      prev_q     <= w_in;
      irq_en_q   <= irq_en_d;
      warm_q     <= warm_d;
      rd_valid_q <= rd_en;
      irq_q      <= irq_d;
      if (rd_en) begin
        rd_data_q <= w_rd_mux;
      end
    end
  end

  assign pin_out  = out_q;
  assign pin_oe   = dir_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire
